// File: rtl/col2im_accumulator.sv
// ============================================================================
//  Module   : col2im_accumulator
//  Purpose  : Overlap-adds unrolled KHxKW windows into a row ring and streams
//             out each finished image row, channel-interleaved raster order.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module col2im_accumulator #(
  parameter int DATA_WIDTH    = 32,
  parameter int IMG_WIDTH     = 4,
  parameter int IMG_HEIGHT    = 3,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 2,
  parameter int CHANNELS      = 2,
  parameter int OUT_WIDTH     = DATA_WIDTH + $clog2(KERNEL_WIDTH * KERNEL_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in [KERNEL_HEIGHT*KERNEL_WIDTH],
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic signed [OUT_WIDTH-1:0]  data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic                         data_out_last
);

  localparam int N       = KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int ROW_LEN = IMG_WIDTH * CHANNELS;
  localparam int WX_MAX  = IMG_WIDTH - KERNEL_WIDTH;
  localparam int WY_MAX  = IMG_HEIGHT - KERNEL_HEIGHT;

  localparam int WXW = (WX_MAX > 0) ? $clog2(WX_MAX + 1) : 1;
  localparam int WYW = (WY_MAX > 0) ? $clog2(WY_MAX + 1) : 1;
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int COLW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int DRW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int RLW = $clog2(KERNEL_HEIGHT + 1);

  localparam logic [WXW-1:0]  WX_LAST  = WXW'(WX_MAX);
  localparam logic [WYW-1:0]  WY_LAST  = WYW'(WY_MAX);
  localparam logic [CW-1:0]   C_LAST   = CW'(CHANNELS - 1);
  localparam logic [COLW-1:0] COL_LAST = COLW'(ROW_LEN - 1);
  localparam logic [DRW-1:0]  ROW_LAST = DRW'(IMG_HEIGHT - 1);
  localparam logic [RLW-1:0]  RL_FULL  = RLW'(KERNEL_HEIGHT);
  localparam logic [RLW-1:0]  RL_ONE   = RLW'(1);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                      state_q;
  logic [WXW-1:0]              wx_q;
  logic [WYW-1:0]              wy_q;
  logic [CW-1:0]               c_q;
  logic [COLW-1:0]             col_q;
  logic [DRW-1:0]              drain_row_q;
  logic [RLW-1:0]              rows_left_q;
  logic signed [OUT_WIDTH-1:0] acc_q [KERNEL_HEIGHT][ROW_LEN];

  int w_drain_slot;

  assign w_drain_slot   = int'(drain_row_q) % KERNEL_HEIGHT;
  assign data_in_ready  = (state_q == S_ACCUM);
  assign data_out_valid = (state_q == S_DRAIN);
  assign data_out       = acc_q[w_drain_slot][int'(col_q)];
  assign data_out_last  = (state_q == S_DRAIN) && (drain_row_q == ROW_LAST) &&
                          (col_q == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      wx_q        <= '0;
      wy_q        <= '0;
      c_q         <= '0;
      col_q       <= '0;
      drain_row_q <= '0;
      rows_left_q <= '0;
      for (int s = 0; s < KERNEL_HEIGHT; s++) begin
        for (int k = 0; k < ROW_LEN; k++) begin
          acc_q[s][k] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (data_in_valid) begin
            // Every (j,i) hits a distinct ring entry, so all adds land in one cycle.
            for (int j = 0; j < KERNEL_HEIGHT; j++) begin
              for (int i = 0; i < KERNEL_WIDTH; i++) begin
                acc_q[(int'(wy_q) + j) % KERNEL_HEIGHT][(int'(wx_q) + i) * CHANNELS + int'(c_q)] <=
                  acc_q[(int'(wy_q) + j) % KERNEL_HEIGHT][(int'(wx_q) + i) * CHANNELS + int'(c_q)] +
                  OUT_WIDTH'(data_in[N - 1 - (j * KERNEL_WIDTH + i)]);
              end
            end
            if (c_q == C_LAST) begin
              c_q <= '0;
              if (wx_q == WX_LAST) begin
                wx_q        <= '0;
                state_q     <= S_DRAIN;
                drain_row_q <= DRW'(wy_q);
                if (wy_q == WY_LAST) begin
                  rows_left_q <= RL_FULL;
                  wy_q        <= '0;
                end else begin
                  rows_left_q <= RL_ONE;
                  wy_q        <= wy_q + 1'b1;
                end
              end else begin
                wx_q <= wx_q + 1'b1;
              end
            end else begin
              c_q <= c_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (data_out_ready) begin
            // Clearing on read leaves the slot ready for the row that reuses it.
            acc_q[w_drain_slot][int'(col_q)] <= '0;
            if (col_q == COL_LAST) begin
              col_q       <= '0;
              rows_left_q <= rows_left_q - 1'b1;
              if (drain_row_q == ROW_LAST) begin
                drain_row_q <= '0;
              end else begin
                drain_row_q <= drain_row_q + 1'b1;
              end
              if (rows_left_q == RL_ONE) begin
                state_q <= S_ACCUM;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= S_ACCUM;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_col2im_accumulator.sv
// ============================================================================
//  Module   : tb_col2im_accumulator
//  Purpose  : Directed self-checking bench for col2im_accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_col2im_accumulator;

  localparam int DW      = 32;
  localparam int IW      = 4;
  localparam int IH      = 3;
  localparam int KW      = 3;
  localparam int KH      = 2;
  localparam int CH      = 2;
  localparam int N       = KH * KW;
  localparam int OW      = DW + $clog2(N);
  localparam int ROW_LEN = IW * CH;
  localparam int TOTAL   = IH * ROW_LEN;
  localparam int NWX     = IW - KW + 1;
  localparam int NWY     = IH - KH + 1;
  localparam int NWIN    = NWX * NWY * CH;
  localparam int LIM     = 400;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] data_in [N];
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic signed [OW-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 data_out_last;

  col2im_accumulator #(
    .DATA_WIDTH   (DW),
    .IMG_WIDTH    (IW),
    .IMG_HEIGHT   (IH),
    .KERNEL_WIDTH (KW),
    .KERNEL_HEIGHT(KH),
    .CHANNELS     (CH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last (data_out_last)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q [TOTAL];

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int elem(input int mode, input int j, input int i, input int c);
    case (mode)
      0:       return 1;
      1:       return 100 * j + 10 * i + c + 1;
      2:       return -1;
      default: return 0;
    endcase
  endfunction

  // Modes 0/2 use the hand-derived coverage table; others use a plain col2im model.
  task automatic build_exp(input int mode);
    int row_a [ROW_LEN] = '{1, 1, 2, 2, 2, 2, 1, 1};
    if (mode == 0 || mode == 2) begin
      for (int k = 0; k < ROW_LEN; k++) begin
        exp_q[k]               = (mode == 0 ? 1 : -1) * row_a[k];
        exp_q[ROW_LEN + k]     = (mode == 0 ? 2 : -2) * row_a[k];
        exp_q[2 * ROW_LEN + k] = (mode == 0 ? 1 : -1) * row_a[k];
      end
    end else begin
      for (int k = 0; k < TOTAL; k++) exp_q[k] = 0;
      for (int wy = 0; wy < NWY; wy++)
        for (int wx = 0; wx < NWX; wx++)
          for (int c = 0; c < CH; c++)
            for (int j = 0; j < KH; j++)
              for (int i = 0; i < KW; i++)
                exp_q[(wy + j) * ROW_LEN + (wx + i) * CH + c] += elem(mode, j, i, c);
    end
  endtask

  task automatic send_windows(input int mode, input int count);
    for (int w = 0; w < count; w++) begin
      int  wx = (w / CH) % NWX;
      int  c  = w % CH;
      int  t  = 0;
      bit  ok = 1'b0;
      for (int j = 0; j < KH; j++)
        for (int i = 0; i < KW; i++)
          data_in[N - 1 - (j * KW + i)] = elem(mode, j, i, c) + 0 * wx;
      data_in_valid = 1'b1;
      do begin
        #1;
        ok = data_in_ready;
        @(negedge clk);
        t++;
      end while (!ok && t < LIM);
      if (!ok) begin
        chk("in_timeout", 0, 1);
        break;
      end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic collect(input bit rnd);
    int     beats   = 0;
    int     cyc     = 0;
    bit     stalled = 1'b0;
    longint held    = 0;
    while (beats < TOTAL && cyc < 4 * LIM) begin
      data_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (data_out_valid) begin
        chk("in_ready_during_drain", longint'(data_in_ready), 0);
        if (stalled) chk("stall_hold", longint'(data_out), held);
        if (data_out_ready) begin
          chk($sformatf("beat%0d", beats), longint'(data_out), exp_q[beats]);
          chk($sformatf("last%0d", beats), longint'(data_out_last),
              longint'(beats == TOTAL - 1));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = longint'(data_out);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (beats < TOTAL) chk("out_timeout", beats, TOTAL);
    data_out_ready = 1'b1;
  endtask

  task automatic run_frame(input int mode, input bit rnd);
    build_exp(mode);
    fork
      send_windows(mode, NWIN);
      collect(rnd);
    join
  endtask

  initial begin
    rst            = 1'b1;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    for (int e = 0; e < N; e++) data_in[e] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", longint'(data_in_ready), 1);
    chk("rst_out_valid", longint'(data_out_valid), 0);
    chk("rst_out_last", longint'(data_out_last), 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(1, 1'b1);
    run_frame(2, 1'b0);
    run_frame(0, 1'b0);
    run_frame(3, 1'b0);

    // Reset in the middle of accumulation.
    send_windows(0, 3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_acc_rst_out_valid", longint'(data_out_valid), 0);
    chk("mid_acc_rst_in_ready", longint'(data_in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 1'b0);

    // Reset while a row is waiting to drain.
    data_out_ready = 1'b0;
    send_windows(1, NWX * CH);
    #1;
    chk("pre_rst_draining", longint'(data_out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_drain_rst_out_valid", longint'(data_out_valid), 0);
    chk("mid_drain_rst_in_ready", longint'(data_in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
